// File: rtl/vga_sync_detector.sv
// Measures incoming VGA HS/VS timing, locks when it matches the configured mode,
// and reports pixel coordinates for the active area once locked.
module vga_sync_detector #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_VISIBLE   = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_VISIBLE   = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLK_25M,
  input  logic       FPGA_RST,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  output logic [9:0] H_Count,
  output logic [9:0] V_Count,
  output logic [9:0] Pixel_X,
  output logic [9:0] Pixel_Y,
  output logic       Data_valid,
  output logic       Locked,
  output logic [9:0] Line_Len,
  output logic [9:0] Frame_Len,
  output logic       Sync_Err
);

  localparam logic [10:0] H_TOT    = 11'(H_TOTAL);
  localparam logic [10:0] H_SYN    = 11'(H_SYNC);
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
  localparam logic [9:0]  V_SYN    = 10'(V_SYNC);
  localparam logic [9:0]  HA_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  HA_END   = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0]  VA_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  VA_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX  = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      state, state_next;
  logic [7:0]  good_cnt, good_next;
  logic        err_hist, hist_next;
  logic        hs_r, vs_r;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [10:0] h_inc, v_inc;
  logic [10:0] hs_width;
  logic [9:0]  h_next, v_next;
  logic [9:0]  vs_width;
  logic        line_err, frame_bad, lost;

  assign hs_fall  = hs_r & ~VGA_HS;
  assign hs_rise  = ~hs_r & VGA_HS;
  assign vs_fall  = vs_r & ~VGA_VS;
  assign vs_rise  = ~vs_r & VGA_VS;
  assign h_inc    = {1'b0, H_Count} + 11'd1;
  assign v_inc    = {1'b0, V_Count} + 11'd1;
  assign hs_width = h_inc;

  always_comb begin
    h_next = (H_Count == CNT_MAX) ? H_Count : h_inc[9:0];
    if (hs_fall) h_next = '0;
    v_next = V_Count;
    if (hs_fall && V_Count != CNT_MAX) v_next = v_inc[9:0];
    if (vs_fall) v_next = '0;
  end

  assign line_err  = (hs_fall && h_inc != H_TOT) || (hs_rise && hs_width != H_SYN);
  // A line error on the closing edge itself belongs to the frame being closed.
  assign frame_bad = (v_inc != V_TOT) || (vs_width != V_SYN) || err_hist || line_err;
  // A resuming HS edge is not a loss, so the first vs_fall after recovery still counts.
  assign lost      = (H_Count == CNT_MAX) && !hs_fall;

  always_ff @(posedge CLK_25M or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      H_Count   <= '0;
      V_Count   <= '0;
      Line_Len  <= '0;
      Frame_Len <= '0;
      vs_width  <= '0;
    end else begin
      hs_r    <= VGA_HS;
      vs_r    <= VGA_VS;
      H_Count <= h_next;
      V_Count <= v_next;
      if (hs_fall) Line_Len  <= h_inc[9:0];
      if (vs_fall) Frame_Len <= v_inc[9:0];
      if (vs_rise) vs_width  <= v_next;
    end
  end

  always_ff @(posedge CLK_25M or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      state    <= SEARCH;
      good_cnt <= '0;
      err_hist <= 1'b0;
      Locked   <= 1'b0;
      Sync_Err <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      err_hist <= hist_next;
      Locked   <= (state_next == LOCKED);
      Sync_Err <= (state != SEARCH) && (line_err || (vs_fall && frame_bad));
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    hist_next  = err_hist | line_err;
    case (state)
      SEARCH: begin
        hist_next = 1'b0;
        good_next = '0;
        if (vs_fall) state_next = CHECK;
      end
      CHECK: begin
        if (vs_fall) begin
          hist_next = 1'b0;
          if (frame_bad) begin
            good_next = '0;
          end else begin
            good_next = good_cnt + 8'd1;
            if (good_next >= LOCK_N) state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (vs_fall) hist_next = 1'b0;
        if (line_err || (vs_fall && frame_bad)) begin
          state_next = CHECK;
          good_next  = '0;
        end
      end
      default: state_next = SEARCH;
    endcase
    if (lost) begin
      state_next = SEARCH;
      good_next  = '0;
      hist_next  = 1'b0;
    end
  end

  always_comb begin
    Data_valid = Locked && (H_Count >= HA_START) && (H_Count < HA_END) &&
                 (V_Count >= VA_START) && (V_Count < VA_END);
    Pixel_X = Data_valid ? (H_Count - HA_START) : '0;
    Pixel_Y = Data_valid ? (V_Count - VA_START) : '0;
  end

endmodule

// File: doc/vga_sync_detector.md
VGA_SYNC_DETECTOR -- requirements
Module: vga_sync_detector

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_TOTAL, 800, clocks per line
- H_SYNC, 96, HS low width
- H_BACK, 48, back porch
- H_VISIBLE, 640, active pixels
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, VS low width in lines
- V_BACK, 33, back porch lines
- V_VISIBLE, 480, active lines
- LOCK_FRAMES, 2, consecutive good frames to lock
REQ-002 SHALL have ports (name direction width meaning):
- CLK_25M in 1 pixel clock, all logic on rising edge
- FPGA_RST in 1 asynchronous active-high reset
- VGA_HS in 1 horizontal sync, active low, synchronous to CLK_25M
- VGA_VS in 1 vertical sync, active low, synchronous to CLK_25M
- H_Count out 10 clocks since last HS falling edge
- V_Count out 10 lines since last VS falling edge
- Pixel_X out 10 active-area column
- Pixel_Y out 10 active-area row
- Data_valid out 1 current pixel in active area and locked
- Locked out 1 timing matches parameters
- Line_Len out 10 last measured line period
- Frame_Len out 10 last measured frame length in lines
- Sync_Err out 1 one-cycle mismatch pulse

Function
REQ-003 SHALL register VGA_HS/VGA_VS once (HS_r, VS_r); hs_fall = HS_r & ~VGA_HS, hs_rise = ~HS_r & VGA_HS; vs_fall/vs_rise likewise.
REQ-004 SHALL, on hs_fall: H_Count<=0 and Line_Len<=H_Count+1; otherwise H_Count increments, saturating at 1023.
REQ-005 SHALL, on hs_rise, capture hs_width = H_Count+1.
REQ-006 SHALL, on vs_fall: V_Count<=0 and Frame_Len<=V_Count+1; otherwise V_Count increments on hs_fall, saturating at 1023. Simultaneous vs_fall and hs_fall: V_Count<=0 wins.
REQ-007 SHALL, on vs_rise, capture vs_width = the V_Count value after that edge (includes a simultaneous hs_fall increment).
REQ-008 SHALL flag a line error when, outside SEARCH: at hs_fall, H_Count+1 != H_TOTAL; or at hs_rise, H_Count+1 != H_SYNC.
REQ-009 SHALL flag a frame error when, at vs_fall: V_Count+1 != V_TOTAL, or the last vs_width != V_SYNC, or any line error occurred since the previous vs_fall.
REQ-010 SHALL implement the lock FSM (SEARCH, CHECK, LOCKED):
- SEARCH -> CHECK on vs_fall; clears good count and error history.
- CHECK at vs_fall: good frame increments good count; good count reaching LOCK_FRAMES -> LOCKED; bad frame clears good count and stays in CHECK.
- LOCKED -> CHECK on the first line error or a bad frame; good count cleared.
- Any state -> SEARCH when H_Count reaches 1023 (lost HS).
REQ-011 SHALL register Locked = (state==LOCKED); it SHALL deassert the cycle after the error edge.
REQ-012 SHALL pulse Sync_Err high for one cycle on each line or frame error detected in CHECK or LOCKED; errors in SEARCH are ignored.
REQ-013 SHALL drive Data_valid combinationally as Locked && H_SYNC+H_BACK <= H_Count < H_SYNC+H_BACK+H_VISIBLE && V_SYNC+V_BACK <= V_Count < V_SYNC+V_BACK+V_VISIBLE.
REQ-014 SHALL drive Pixel_X = H_Count-(H_SYNC+H_BACK) and Pixel_Y = V_Count-(V_SYNC+V_BACK) when Data_valid is high, else 0.

Reset
REQ-015 SHALL, while FPGA_RST is high (asynchronous, any time including mid-frame), force:
- HS_r=1, VS_r=1
- H_Count, V_Count, Line_Len, Frame_Len = 0
- Locked, Sync_Err, Data_valid = 0
- state SEARCH, good count 0
REQ-016 SHALL resume counting on the first rising CLK_25M edge after FPGA_RST falls.

Verification
REQ-017 Reset pulse, no sync activity -> all outputs 0, Locked=0.
REQ-018 Ideal 800/96/525/2 timing with HS and VS falling together -> Line_Len=800, Frame_Len=525; Locked rises the cycle after the third vs_fall.
REQ-019 While locked -> exactly 307200 Data_valid cycles per frame; first valid at H_Count=144, V_Count=35, Pixel_X=0, Pixel_Y=0; last valid at Pixel_X=639, Pixel_Y=479.
REQ-020 Locked, one line stretched to 801 clocks -> Sync_Err one cycle, Locked=0 next cycle, relock after 2 further good frames.
REQ-021 VGA_HS held high 1024+ clocks -> H_Count=1023, state SEARCH, Locked=0; normal timing then relocks after 3 vs_falls.
REQ-022 FPGA_RST asserted mid-line while locked -> outputs cleared immediately without a clock edge; relock as REQ-018.
